// File: rtl/pifo_calendar_v0_2_if.sv
// Insert / pop / drop / status bundle between the buffer manager, the
// egress scheduler and the PIFO calendar.
interface pifo_calendar_v0_2_if #(
  parameter int DEPTH      = 16,
  parameter int RANK_WIDTH = 19,
  parameter int DATA_WIDTH = 12
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  in_ins_valid;
  logic [RANK_WIDTH-1:0] in_ins_rank;
  logic [DATA_WIDTH-1:0] in_ins_data;
  logic                  out_ins_ready;
  logic                  out_pop_valid;
  logic [RANK_WIDTH-1:0] out_pop_rank;
  logic [DATA_WIDTH-1:0] out_pop_data;
  logic                  in_pop_ready;
  logic                  out_drop_valid;
  logic [RANK_WIDTH-1:0] out_drop_rank;
  logic [DATA_WIDTH-1:0] out_drop_data;
  logic [CW-1:0]         out_count;
  logic                  out_full;
  logic                  out_empty;

  modport slave (
    input  in_ins_valid, in_ins_rank, in_ins_data, in_pop_ready,
    output out_ins_ready, out_pop_valid, out_pop_rank, out_pop_data,
           out_drop_valid, out_drop_rank, out_drop_data,
           out_count, out_full, out_empty
  );

  modport master (
    output in_ins_valid, in_ins_rank, in_ins_data, in_pop_ready,
    input  out_ins_ready, out_pop_valid, out_pop_rank, out_pop_data,
           out_drop_valid, out_drop_rank, out_drop_data,
           out_count, out_full, out_empty
  );
endinterface

// File: rtl/pifo_calendar_v0_2.sv
// PIFO calendar: DEPTH-entry shift-register array kept sorted by rank,
// head (entry 0) holds the smallest rank. Equal ranks stay in arrival order.
// Optional push-out policy evicts the largest rank when a better one arrives
// while full.
module pifo_calendar_v0_2 #(
  parameter int DEPTH      = 16,
  parameter int RANK_WIDTH = 19,
  parameter int DATA_WIDTH = 12,
  parameter int PUSHOUT    = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  pifo_calendar_v0_2_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [RANK_WIDTH-1:0] rank_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  rank_t            rank_q [DEPTH];
  rank_t            rank_d [DEPTH];
  data_t            data_q [DEPTH];
  data_t            data_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             drop_valid_q, drop_valid_d;
  rank_t            drop_rank_q, drop_rank_d;
  data_t            drop_data_q, drop_data_d;

  logic             full;
  logic             ins_fire;
  logic             pop_fire;
  logic [DEPTH-1:0] gt;
  int               pos;
  int               slot;

  assign full     = (count_q == CW'(DEPTH));
  assign ins_fire = bus.in_ins_valid & bus.out_ins_ready;
  assign pop_fire = valid_q[0] & bus.in_pop_ready;

  assign bus.out_ins_ready  = ~full | (PUSHOUT != 0);
  assign bus.out_pop_valid  = valid_q[0];
  assign bus.out_pop_rank   = rank_q[0];
  assign bus.out_pop_data   = data_q[0];
  assign bus.out_drop_valid = drop_valid_q;
  assign bus.out_drop_rank  = drop_rank_q;
  assign bus.out_drop_data  = drop_data_q;
  assign bus.out_count      = count_q;
  assign bus.out_full       = full;
  assign bus.out_empty      = (count_q == '0);

  // Per-entry strict compare and first-greater position (DEPTH = no slot).
  always_comb begin
    pos = DEPTH;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      gt[i] = ~valid_q[i] | (bus.in_ins_rank < rank_q[i]);
      if (gt[i]) pos = i;
    end
    // With a simultaneous pop everything moves one toward the head first.
    slot = (pos == 0) ? 0 : pos - 1;
  end

  // Next array contents, count and drop report for insert / pop / both.
  always_comb begin
    valid_d      = valid_q;
    rank_d       = rank_q;
    data_d       = data_q;
    count_d      = count_q;
    drop_valid_d = 1'b0;
    drop_rank_d  = drop_rank_q;
    drop_data_d  = drop_data_q;

    if (ins_fire && pop_fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i < slot) begin
          valid_d[i] = valid_q[i+1];
          rank_d[i]  = rank_q[i+1];
          data_d[i]  = data_q[i+1];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (i == slot) begin
          valid_d[i] = 1'b1;
          rank_d[i]  = bus.in_ins_rank;
          data_d[i]  = bus.in_ins_data;
        end
      end
    end else if (ins_fire) begin
      if (pos < DEPTH) begin
        for (int i = 1; i < DEPTH; i++) begin
          if (i > pos) begin
            valid_d[i] = valid_q[i-1];
            rank_d[i]  = rank_q[i-1];
            data_d[i]  = data_q[i-1];
          end
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (i == pos) begin
            valid_d[i] = 1'b1;
            rank_d[i]  = bus.in_ins_rank;
            data_d[i]  = bus.in_ins_data;
          end
        end
        if (!full) count_d = count_q + CW'(1);
      end
      // Only reachable with push-out: evict the old tail or refuse the newcomer.
      if (full) begin
        drop_valid_d = 1'b1;
        if (pos < DEPTH) begin
          drop_rank_d = rank_q[DEPTH-1];
          drop_data_d = data_q[DEPTH-1];
        end else begin
          drop_rank_d = bus.in_ins_rank;
          drop_data_d = bus.in_ins_data;
        end
      end
    end else if (pop_fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        valid_d[i] = valid_q[i+1];
        rank_d[i]  = rank_q[i+1];
        data_d[i]  = data_q[i+1];
      end
      valid_d[DEPTH-1] = 1'b0;
      count_d          = count_q - CW'(1);
    end
  end

  // State registers; reset wipes contents without reporting drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q      <= '0;
      count_q      <= '0;
      drop_valid_q <= 1'b0;
      drop_rank_q  <= '0;
      drop_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rank_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      count_q      <= count_d;
      drop_valid_q <= drop_valid_d;
      drop_rank_q  <= drop_rank_d;
      drop_data_q  <= drop_data_d;
      for (int i = 0; i < DEPTH; i++) begin
        rank_q[i] <= rank_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end
endmodule
